// File: rtl/ristretto_dmem_responder.sv
// Single-port data-memory responder for the Ristretto core: a valid/ready request channel,
// a fixed-latency access pipeline and a held response until the initiator takes it.
module ristretto_dmem_responder #(
    parameter int MEM_DEPTH      = 1024,
    parameter int ACCESS_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int         IDX_W          = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [2:0] LAT            = 3'(ACCESS_LATENCY);
    localparam logic [1:0] MEM_SIZE_WORD  = 2'b01;
    localparam logic [1:0] MEM_SIZE_HALF  = 2'b10;
    localparam logic [1:0] MEM_SIZE_BYTE  = 2'b11;

    typedef enum logic [1:0] {
        RSP_IDLE  = 2'b00,
        RSP_BUSY  = 2'b01,
        RSP_VALID = 2'b10
    } rsp_state_e;

    rsp_state_e      state_q;
    logic [2:0]      count_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic            we_q;
    logic [1:0]      size_q;
    logic            err_q;
    logic [31:0]     rd_word_q;
    logic [31:0]     mem [MEM_DEPTH];

    logic            access_fire;
    logic            mem_en;
    logic            acc_we;
    logic [1:0]      acc_size;
    logic [31:0]     acc_addr;
    logic [31:0]     acc_wdata;
    logic            acc_err;
    logic [3:0]      acc_be;
    logic [31:0]     acc_lanes;
    logic [IDX_W-1:0] acc_idx;

    function automatic logic access_fault(input logic [1:0] size, input logic [31:0] addr);
        logic fault;
        fault = 1'b0;
        case (size)
            2'b00:         fault = 1'b1;
            MEM_SIZE_WORD: fault = (addr[1:0] != 2'b00);
            MEM_SIZE_HALF: fault = addr[0];
            default:       fault = 1'b0;
        endcase
        if ({2'b00, addr[31:2]} >= 32'(MEM_DEPTH)) begin
            fault = 1'b1;
        end
        return fault;
    endfunction

    // With zero latency the access happens on the handshake edge itself, so it must use
    // the live request inputs; otherwise it uses the registers captured at the handshake.
    generate
        if (ACCESS_LATENCY == 0) begin : g_direct
            assign access_fire = req_valid_i && (state_q == RSP_IDLE);
            assign acc_we      = req_we_i;
            assign acc_size    = req_size_i;
            assign acc_addr    = req_addr_i;
            assign acc_wdata   = req_wdata_i;
        end else begin : g_busy
            assign access_fire = (state_q == RSP_BUSY) && (count_q <= 3'd1);
            assign acc_we      = we_q;
            assign acc_size    = size_q;
            assign acc_addr    = addr_q;
            assign acc_wdata   = wdata_q;
        end
    endgenerate

    assign mem_en  = access_fire && rst_n_i;
    assign acc_err = access_fault(acc_size, acc_addr);
    assign acc_idx = acc_addr[IDX_W+1:2];

    always_comb begin
        acc_be    = 4'b0000;
        acc_lanes = acc_wdata;
        case (acc_size)
            MEM_SIZE_WORD: acc_be = 4'b1111;
            MEM_SIZE_HALF: begin
                acc_be    = acc_addr[1] ? 4'b1100 : 4'b0011;
                acc_lanes = {2{acc_wdata[15:0]}};
            end
            MEM_SIZE_BYTE: begin
                acc_be    = 4'b0001 << acc_addr[1:0];
                acc_lanes = {4{acc_wdata[7:0]}};
            end
            default: acc_be = 4'b0000;
        endcase
    end

    // Byte-enabled single-port RAM: each access is either one lane-masked write or one read.
    always_ff @(posedge clk_i) begin
        if (mem_en && !acc_err) begin
            if (acc_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (acc_be[b]) begin
                        mem[acc_idx][8*b +: 8] <= acc_lanes[8*b +: 8];
                    end
                end
            end else begin
                rd_word_q <= mem[acc_idx];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= RSP_IDLE;
            count_q <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                RSP_IDLE: begin
                    if (req_valid_i) begin
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        we_q    <= req_we_i;
                        size_q  <= req_size_i;
                        if (ACCESS_LATENCY == 0) begin
                            state_q <= RSP_VALID;
                            err_q   <= acc_err;
                        end else begin
                            state_q <= RSP_BUSY;
                            count_q <= LAT;
                        end
                    end
                end
                RSP_BUSY: begin
                    if (count_q <= 3'd1) begin
                        state_q <= RSP_VALID;
                        count_q <= 3'd0;
                        err_q   <= acc_err;
                    end else begin
                        count_q <= count_q - 3'd1;
                    end
                end
                RSP_VALID: begin
                    if (rsp_ready_i) begin
                        state_q <= RSP_IDLE;
                        err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= RSP_IDLE;
                    count_q <= 3'd0;
                end
            endcase
        end
    end

    assign req_ready_o = (state_q == RSP_IDLE);
    assign rsp_valid_o = (state_q == RSP_VALID);
    assign rsp_err_o   = err_q;

    // Lane select and zero-extension; everything feeding this is held while VALID waits.
    always_comb begin
        rsp_rdata_o = 32'd0;
        if ((state_q == RSP_VALID) && !we_q && !err_q) begin
            case (size_q)
                MEM_SIZE_WORD: rsp_rdata_o = rd_word_q;
                MEM_SIZE_HALF: rsp_rdata_o = {16'd0, addr_q[1] ? rd_word_q[31:16] : rd_word_q[15:0]};
                MEM_SIZE_BYTE: begin
                    case (addr_q[1:0])
                        2'd0:    rsp_rdata_o = {24'd0, rd_word_q[7:0]};
                        2'd1:    rsp_rdata_o = {24'd0, rd_word_q[15:8]};
                        2'd2:    rsp_rdata_o = {24'd0, rd_word_q[23:16]};
                        default: rsp_rdata_o = {24'd0, rd_word_q[31:24]};
                    endcase
                end
                default: rsp_rdata_o = 32'd0;
            endcase
        end
    end

endmodule
